// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit with HI/LO result registers. MUL uses shift-add
// and DIV uses restoring shift-subtract, each retiring one bit per cycle.
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] s_in,
    input  logic [WIDTH-1:0] t_in,
    input  logic             mt_hi,
    input  logic             mt_lo,
    input  logic [WIDTH-1:0] mt_data,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, FIN} state_t;

    state_t             state_q, state_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   m_q, m_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               is_div_q, is_div_d;
    logic               neg_q, neg_d;
    logic               rem_neg_q, rem_neg_d;
    logic               tz_q, tz_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               div_zero_q, div_zero_d;

    logic               s_neg, t_neg;
    logic [WIDTH-1:0]   s_abs, t_abs;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo, rem;

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        m_d        = m_q;
        cnt_d      = cnt_q;
        is_div_d   = is_div_q;
        neg_d      = neg_q;
        rem_neg_d  = rem_neg_q;
        tz_d       = tz_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        div_zero_d = div_zero_q;

        s_neg    = op[0] & s_in[WIDTH-1];
        t_neg    = op[0] & t_in[WIDTH-1];
        s_abs    = s_neg ? -s_in : s_in;
        t_abs    = t_neg ? -t_in : t_in;
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, m_q};
        div_diff = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, m_q};
        prod     = neg_q ? -acc_q : acc_q;
        quo      = acc_q[WIDTH-1:0];
        rem      = acc_q[2*WIDTH-1:WIDTH];

        case (state_q)
            IDLE: begin
                if (start && !flush) begin
                    state_d    = op[1] ? DIV : MUL;
                    acc_d      = {{WIDTH{1'b0}}, (op[1] ? s_abs : t_abs)};
                    m_d        = op[1] ? t_abs : s_abs;
                    cnt_d      = '0;
                    is_div_d   = op[1];
                    neg_d      = s_neg ^ t_neg;
                    rem_neg_d  = s_neg;
                    tz_d       = (t_in == '0);
                    div_zero_d = 1'b0;
                end else begin
                    if (mt_hi) hi_d = mt_data;
                    if (mt_lo) lo_d = mt_data;
                end
            end
            MUL: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    acc_d = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]}
                                     : {1'b0, acc_q[2*WIDTH-1:1]};
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
                end
            end
            DIV: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    // A negative trial difference means the shifted remainder is kept.
                    acc_d = div_diff[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                            : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
                end
            end
            FIX: begin
                state_d = IDLE;
                if (!flush) begin
                    state_d = FIN;
                    if (is_div_q) begin
                        hi_d       = rem_neg_q ? -rem : rem;
                        lo_d       = tz_q ? '1 : (neg_q ? -quo : quo);
                        div_zero_d = tz_q;
                    end else begin
                        {hi_d, lo_d} = prod;
                    end
                end
            end
            FIN: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            m_q        <= '0;
            cnt_q      <= '0;
            is_div_q   <= 1'b0;
            neg_q      <= 1'b0;
            rem_neg_q  <= 1'b0;
            tz_q       <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            m_q        <= m_d;
            cnt_q      <= cnt_d;
            is_div_q   <= is_div_d;
            neg_q      <= neg_d;
            rem_neg_q  <= rem_neg_d;
            tz_q       <= tz_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign busy     = (state_q == MUL) || (state_q == DIV) || (state_q == FIX);
    assign done     = (state_q == FIN);
    assign div_zero = div_zero_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: expected HI/LO/div_zero come from a longint
// reference model, queued at start and compared when done pulses.
module tb_mul_div_unit;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             flush = 1'b0;
    logic             start = 1'b0;
    logic [1:0]       op = 2'b00;
    logic [WIDTH-1:0] sIn = '0;
    logic [WIDTH-1:0] tIn = '0;
    logic             mtHi = 1'b0;
    logic             mtLo = 1'b0;
    logic [WIDTH-1:0] mtData = '0;
    logic             busy, done, divZero;
    logic [WIDTH-1:0] hi, lo;

    typedef struct {
        logic [63:0] hiLo;
        logic        dz;
    } exp_t;

    exp_t        sbq[$];
    int          total = 0;
    int          bad = 0;
    int          edgeIdx = 0;
    logic [63:0] curHiLo = '0;
    logic        curDz = 1'b0;

    mul_div_unit #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .flush(flush), .start(start), .op(op),
        .s_in(sIn), .t_in(tIn), .mt_hi(mtHi), .mt_lo(mtLo), .mt_data(mtData),
        .busy(busy), .done(done), .div_zero(divZero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    // Reference model: 64-bit signed arithmetic truncates toward zero with remainder sign of dividend.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] s, input logic [31:0] t);
        longint sl, tl, q, r, p;
        sl = o[0] ? {{32{s[31]}}, s} : {32'b0, s};
        tl = o[0] ? {{32{t[31]}}, t} : {32'b0, t};
        if (!o[1]) begin
            p = sl * tl;
            return p;
        end
        if (t == 32'h0) return {s, 32'hFFFF_FFFF};
        q = sl / tl;
        r = sl % tl;
        return {r[31:0], q[31:0]};
    endfunction

    // One comparison point: counts it and reports a failure with observed/expected values.
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic advance(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            edgeIdx++;
        end
    endtask

    // Drives one start pulse; leaves the bench at the negedge of the first cycle after acceptance.
    task automatic applyStimulus(input logic [1:0] o, input logic [31:0] s, input logic [31:0] t, input bit expectResult);
        exp_t e;
        op    = o;
        sIn   = s;
        tIn   = t;
        start = 1'b1;
        if (expectResult) begin
            e.hiLo = model(o, s, t);
            e.dz   = o[1] && (t == 32'h0);
            sbq.push_back(e);
        end
        @(negedge clk);
        start   = 1'b0;
        edgeIdx = 1;
        checkOutput("busy_after_start", {63'b0, busy}, 64'd1);
        checkOutput("dz_cleared_by_start", {63'b0, divZero}, 64'd0);
    endtask

    // Waits (bounded) for done, checks latency and result, optionally pokes start during FIN.
    task automatic waitResult(input bit startInFin);
        exp_t e;
        while (!done && edgeIdx < WIDTH + 20) advance(1);
        if (!done) begin
            checkOutput("done_timeout", 64'd0, 64'd1);
            return;
        end
        checkOutput("latency", 64'(edgeIdx), 64'(WIDTH + 2));
        checkOutput("busy_in_fin", {63'b0, busy}, 64'd0);
        if (sbq.size() == 0) begin
            checkOutput("unexpected_done", 64'd1, 64'd0);
        end else begin
            e = sbq.pop_front();
            checkOutput("hi_lo", {hi, lo}, e.hiLo);
            checkOutput("div_zero", {63'b0, divZero}, {63'b0, e.dz});
            curHiLo = e.hiLo;
            curDz   = e.dz;
        end
        if (startInFin) begin
            op    = 2'b00;
            sIn   = 32'd3;
            tIn   = 32'd3;
            start = 1'b1;
        end
        advance(1);
        start = 1'b0;
        checkOutput("done_one_cycle", {63'b0, done}, 64'd0);
        if (startInFin) checkOutput("start_in_fin_ignored", {63'b0, busy}, 64'd0);
        checkOutput("hi_lo_hold", {hi, lo}, curHiLo);
    endtask

    task automatic watchNoDone(input int n);
        bit seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        checkOutput("no_done", {63'b0, seen}, 64'd0);
    endtask

    task automatic mtWrite(input logic h, input logic l, input logic [31:0] d);
        mtHi   = h;
        mtLo   = l;
        mtData = d;
        @(negedge clk);
        mtHi = 1'b0;
        mtLo = 1'b0;
        if (h) curHiLo[63:32] = d;
        if (l) curHiLo[31:0]  = d;
        checkOutput("mt_write", {hi, lo}, curHiLo);
    endtask

    initial begin
        logic [1:0]  rOp;
        logic [31:0] rS, rT;

        repeat (3) @(negedge clk);
        checkOutput("reset_hi", {32'b0, hi}, 64'd0);
        checkOutput("reset_lo", {32'b0, lo}, 64'd0);
        checkOutput("reset_busy", {63'b0, busy}, 64'd0);
        checkOutput("reset_done", {63'b0, done}, 64'd0);
        checkOutput("reset_dz", {63'b0, divZero}, 64'd0);
        rst = 1'b1;
        @(negedge clk);

        $display("[TB] MULT -3*7, start poked during FIN");
        applyStimulus(2'b01, 32'hFFFF_FFFD, 32'd7, 1'b1);
        waitResult(1'b1);
        checkOutput("mult_const", curHiLo, 64'hFFFF_FFFF_FFFF_FFEB);

        $display("[TB] DIV -7/2");
        applyStimulus(2'b11, 32'hFFFF_FFF9, 32'd2, 1'b1);
        waitResult(1'b0);
        checkOutput("div_const", curHiLo, 64'hFFFF_FFFF_FFFF_FFFD);

        $display("[TB] DIVU 100/0 then start+flush together");
        applyStimulus(2'b10, 32'd100, 32'd0, 1'b1);
        waitResult(1'b0);
        checkOutput("divz_const", {curHiLo, 63'b0, curDz}, {64'h0000_0064_FFFF_FFFF, 64'd1});
        op    = 2'b00;
        start = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        checkOutput("flush_beats_start", {63'b0, busy}, 64'd0);
        checkOutput("dz_sticky", {63'b0, divZero}, 64'd1);
        applyStimulus(2'b00, 32'd5, 32'd6, 1'b1);
        waitResult(1'b0);

        $display("[TB] DIV most-negative / -1");
        applyStimulus(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        waitResult(1'b0);
        checkOutput("minneg_const", curHiLo, 64'h0000_0000_8000_0000);

        $display("[TB] mt write then flush at edge 10");
        mtWrite(1'b1, 1'b1, 32'hA5A5_A5A5);
        applyStimulus(2'b00, 32'd1234, 32'd5678, 1'b0);
        advance(9);
        flush = 1'b1;
        advance(1);
        flush = 1'b0;
        checkOutput("flush_idle", {63'b0, busy}, 64'd0);
        advance(1);
        checkOutput("flush_idle_e11", {63'b0, busy}, 64'd0);
        checkOutput("flush_hi_lo", {hi, lo}, 64'hA5A5_A5A5_A5A5_A5A5);
        watchNoDone(WIDTH + 10);
        mtWrite(1'b0, 1'b1, 32'h0000_1111);

        $display("[TB] second start and mt write while busy");
        applyStimulus(2'b00, 32'd12345, 32'd678, 1'b1);
        advance(3);
        mtHi   = 1'b1;
        mtLo   = 1'b1;
        mtData = 32'h0000_1234;
        advance(1);
        mtHi = 1'b0;
        mtLo = 1'b0;
        checkOutput("mt_ignored_busy", {hi, lo}, curHiLo);
        op    = 2'b11;
        sIn   = 32'h100;
        tIn   = 32'd3;
        start = 1'b1;
        advance(1);
        start = 1'b0;
        waitResult(1'b0);
        watchNoDone(WIDTH + 10);

        $display("[TB] random operations");
        for (int i = 0; i < 4; i++) begin
            rOp = 2'($urandom_range(0, 3));
            rS  = $urandom;
            rT  = (i == 2) ? 32'($urandom_range(1, 9)) : $urandom;
            applyStimulus(rOp, rS, rT, 1'b1);
            waitResult(1'b0);
        end

        $display("[TB] reset at edge 20 of a DIV");
        applyStimulus(2'b11, 32'd1000, 32'd7, 1'b0);
        advance(19);
        rst = 1'b0;
        advance(1);
        rst = 1'b1;
        checkOutput("rst_hi_lo", {hi, lo}, 64'd0);
        checkOutput("rst_flags", {61'b0, busy, done, divZero}, 64'd0);
        watchNoDone(WIDTH + 10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
